// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_transmit instance between NUM_REQ
// byte producers. Each grant launches one frame. The next grant waits until
// the transmitter's busy flag has risen and then fallen again, or until the
// busy-rise timeout expires.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_W-1:0]            data,
    output logic                         uart_en,
    input  logic                         uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         active,
    output logic                         err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [7:0]           cnt_q, cnt_d;

    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [DATA_W-1:0]    win_data;
    logic [PTR_W:0]       scan_sum;
    logic [PTR_W-1:0]     scan_idx;
    logic [PTR_W-1:0]     next_ptr;

    // Scan lanes starting at rr_ptr, wrapping past the top, and take the first request found.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
                win_data  = req_data[scan_idx*DATA_W +: DATA_W];
            end
        end
    end

    // The lane after the current owner becomes the first candidate of the next scan.
    always_comb begin
        next_ptr = owner_q + PTR_W'(1);
        if (owner_q == PTR_W'(NUM_REQ-1)) begin
            next_ptr = '0;
        end
    end

    // Next-state logic and the single-cycle launch/ack/error strobes.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        uart_en  = 1'b0;
        ack      = '0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !uart_busy) begin
                    data_d  = win_data;
                    owner_d = win_idx;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_en      = 1'b1;
                ack[owner_q] = 1'b1;
                rr_ptr_d     = next_ptr;
                cnt_d        = '0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == 8'(BUSY_TIMEOUT-1)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, and latched byte registers. The async reset clears every output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data   = data_q;
    assign owner  = owner_q;
    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter. A behavioural transmitter
// raises busy for a programmable number of cycles after each uart_en. A
// round-robin reference predicts which lane wins each grant.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [W-1:0]   data;
    logic           uart_en;
    logic           uart_busy;
    logic [1:0]     owner;
    logic           active;
    logic           err;

    int tests = 0;
    int fails = 0;
    int exp_ptr = 0;
    int busy_len = 10;
    bit busy_respond = 1'b1;
    int frame_left = 0;
    bit start_pend = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (W),
        .BUSY_TIMEOUT (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .data      (data),
        .uart_en   (uart_en),
        .uart_busy (uart_busy),
        .owner     (owner),
        .active    (active),
        .err       (err)
    );

    // Free-running clock.
    initial begin
        forever #5 clk = ~clk;
    end

    // Behavioural transmitter. Busy rises the cycle after uart_en and stays high for busy_len cycles.
    // A reset of the arbiter does not abort a frame that is already running.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (frame_left > 0) frame_left--;
            if (start_pend) begin
                frame_left = busy_len;
                start_pend = 1'b0;
            end
            if (uart_en === 1'b1 && busy_respond) start_pend = 1'b1;
            uart_busy = (frame_left > 0);
        end
    end

    // Global safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference round-robin choice: the first requesting lane at or after ptr, wrapping.
    function automatic int ref_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Wait for one grant and check it against the reference. At the ack edge,
    // apply the next request and byte pattern, as a producer would.
    task automatic serve(input logic [N-1:0] next_req, input logic [N*W-1:0] next_data,
                         input string name);
        int lane;
        bit seen;
        logic [W-1:0] exp_byte;
        lane = ref_winner(req, exp_ptr);
        exp_byte = (lane >= 0) ? req_data[lane*W +: W] : '0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            tests++;
            if (uart_en === 1'b1 && uart_busy === 1'b1) begin
                fails++;
                $display("[TB] FAIL %s en_while_busy: uart_en=%b busy=%b, expected no launch while busy",
                         name, uart_en, uart_busy);
            end
            if (uart_en === 1'b1) begin
                seen = 1'b1;
                tests++;
                if (lane < 0 || ack !== 4'(1 << lane)) begin
                    fails++;
                    $display("[TB] FAIL %s ack: got %b, expected lane %0d", name, ack, lane);
                end
                tests++;
                if (data !== exp_byte) begin
                    fails++;
                    $display("[TB] FAIL %s data: got %h, expected %h", name, data, exp_byte);
                end
                tests++;
                if (int'(owner) !== lane) begin
                    fails++;
                    $display("[TB] FAIL %s owner: got %0d, expected %0d", name, owner, lane);
                end
                tests++;
                if (active !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL %s active: got %b, expected 1", name, active);
                end
                if (lane >= 0) exp_ptr = (lane + 1) % N;
                req = next_req;
                req_data = next_data;
            end else begin
                tests++;
                if (ack !== '0) begin
                    fails++;
                    $display("[TB] FAIL %s ack_no_en: got %b, expected 0000", name, ack);
                end
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s grant_timeout: no uart_en seen, expected lane %0d", name, lane);
        end
    endtask

    // Follow the frame just launched. Active must hold while busy and drop once busy has fallen.
    task automatic check_frame_done(input string name);
        int c;
        c = 0;
        while (uart_busy !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (uart_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s busy_rise: busy=%b, expected frame to start", name, uart_busy);
        end else begin
            c = 0;
            while (uart_busy === 1'b1 && c < 300) begin
                tests++;
                if (active !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL %s active_in_frame: got %b, expected 1", name, active);
                end
                @(negedge clk);
                c++;
            end
            @(negedge clk);
            tests++;
            if (active !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s active_after_frame: got %b, expected 0", name, active);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (active !== 1'b0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (active !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s idle_wait: active=%b, expected 0", name, active);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
    endtask

    // Reset state, then a quiet idle period with no requests.
    task automatic test_reset();
        int en_count;
        rst = 1'b0;
        req = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({ack, data, uart_en, owner, active, err} !== 17'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got ack=%b data=%h en=%b owner=%0d active=%b err=%b, expected all 0",
                     ack, data, uart_en, owner, active, err);
        end
        rst = 1'b1;
        exp_ptr = 0;
        en_count = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (uart_en === 1'b1 || active === 1'b1 || err === 1'b1) en_count++;
        end
        tests++;
        if (en_count !== 0) begin
            fails++;
            $display("[TB] FAIL idle_quiet: got %0d active cycles, expected 0", en_count);
        end
    endtask

    task automatic test_single();
        logic [N*W-1:0] d;
        d = '0;
        d[7:0] = 8'h75;
        req_data = d;
        busy_len = 10;
        req = 4'b0001;
        serve(4'b0000, d, "single");
        check_frame_done("single");
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] d;
        apply_reset();
        d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_data = d;
        busy_len = 6;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) serve(4'b1111, d, "round_robin");
    endtask

    task automatic test_wrap();
        req = 4'b0100;
        serve(4'b0101, req_data, "wrap_lane2");
        serve(4'b0100, req_data, "wrap_lane0");
        serve(4'b0000, req_data, "wrap_lane2b");
        check_frame_done("wrap");
    endtask

    task automatic test_timeout();
        logic [N*W-1:0] d;
        wait_idle("timeout");
        busy_respond = 1'b0;
        d = req_data;
        d[1*W +: W] = 8'($urandom);
        req_data = d;
        req = 4'b0010;
        serve(4'b0000, d, "timeout_launch");
        for (int k = 1; k <= T + 2; k++) begin
            @(negedge clk);
            tests++;
            if (err !== (k == T)) begin
                fails++;
                $display("[TB] FAIL timeout_err k=%0d: got %b, expected %b", k, err, (k == T));
            end
            if (k == T + 1) begin
                tests++;
                if (active !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL timeout_active: got %b, expected 0", active);
                end
            end
        end
        busy_respond = 1'b1;
        busy_len = 5;
        d[3*W +: W] = 8'($urandom);
        req_data = d;
        req = 4'b1000;
        serve(4'b0000, d, "after_timeout");
        check_frame_done("after_timeout");
    endtask

    task automatic test_reset_mid_frame();
        logic [N*W-1:0] d;
        int c;
        d = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        req_data = d;
        busy_len = 30;
        req = 4'b1111;
        serve(4'b1111, d, "mid_frame_launch");
        c = 0;
        while (uart_busy !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({ack, data, uart_en, owner, active, err} !== 17'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset_outputs: got ack=%b data=%h en=%b owner=%0d active=%b err=%b, expected all 0",
                     ack, data, uart_en, owner, active, err);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
        serve(4'b0000, d, "after_mid_reset");
        wait_idle("after_mid_reset");
    endtask

    // Random request patterns, bytes, frame lengths, and the occasional silent transmitter.
    task automatic test_random();
        logic [N-1:0]   nr;
        logic [N*W-1:0] nd;
        int lane;
        int k;
        req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        req = 4'($urandom_range(1, 15));
        for (int it = 0; it < 40; it++) begin
            lane = ref_winner(req, exp_ptr);
            nr = req;
            nd = req_data;
            for (int i = 0; i < N; i++) begin
                if (i == lane) begin
                    if ($urandom_range(0, 1) == 1) nd[i*W +: W] = 8'($urandom);
                    else nr[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        nr[i] = 1'b1;
                        nd[i*W +: W] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 9) < 2) begin
                    nr[i] = 1'b0;
                end
            end
            if (nr == '0) begin
                k = $urandom_range(0, N - 1);
                nr[k] = 1'b1;
                nd[k*W +: W] = 8'($urandom);
            end
            busy_len = $urandom_range(1, 12);
            busy_respond = ($urandom_range(0, 9) != 0);
            serve(nr, nd, "random");
        end
        busy_respond = 1'b1;
        req = '0;
        wait_idle("random_end");
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
